// File: rtl/seq_div16_if.sv
// Handshake/result bundle between the ALU sequencer (master) and seq_div16 (slave).
// The sgn select only exists when SIGNED_DIV_EN is defined.
interface seq_div16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
`ifdef SIGNED_DIV_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             Sign;
  logic             Zero;
  logic             Parity;
  logic             Overflow;
  logic             DivZero;

  modport master (
`ifdef SIGNED_DIV_EN
    output sgn,
`endif
    output start, X, Y,
    input  busy, done, Q, R, Sign, Zero, Parity, Overflow, DivZero
  );

  modport slave (
`ifdef SIGNED_DIV_EN
    input  sgn,
`endif
    input  start, X, Y,
    output busy, done, Q, R, Sign, Zero, Parity, Overflow, DivZero
  );
endinterface

// File: rtl/seq_div16.sv
// Iterative restoring divider, one quotient bit per clock, with ALU-style flags.
// Optional macro SIGNED_DIV_EN adds the sgn select and truncating signed division.
module seq_div16 #(
  parameter int unsigned WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  seq_div16_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] dvd;       // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] quo;       // quotient being assembled
  logic [CntW-1:0]  cnt;
  logic             neg_q;
  logic             neg_r;
  logic             ovf_pend;

  logic             busy_r, done_r, sign_r, zero_r, parity_r, ovf_r, dz_r;
  logic [WIDTH-1:0] q_r, r_r;

  logic             sgn_in;
  logic             x_neg, y_neg;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;

`ifdef SIGNED_DIV_EN
  assign sgn_in = bus.sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // Operand magnitudes and one restoring step of the iteration.
  always_comb begin
    x_neg  = sgn_in & bus.X[WIDTH-1];
    y_neg  = sgn_in & bus.Y[WIDTH-1];
    x_mag  = x_neg ? -bus.X : bus.X;
    y_mag  = y_neg ? -bus.Y : bus.Y;
    rem_sh = {rem, dvd[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, dvs});
    rem_nx = fits ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], fits};
    // Sign correction happens on the way into the result registers.
    q_fin  = neg_q ? -quo_nx : quo_nx;
    r_fin  = neg_r ? -rem_nx : rem_nx;
  end

  // Control FSM, datapath and registered results/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_pend <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      q_r      <= '0;
      r_r      <= '0;
      sign_r   <= 1'b0;
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
      ovf_r    <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          state <= StIdle;
          if (bus.start) begin
            if (bus.Y != '0) begin
              dvd      <= x_mag;
              dvs      <= y_mag;
              rem      <= '0;
              quo      <= '0;
              cnt      <= CntW'(WIDTH);
              neg_q    <= x_neg ^ y_neg;
              neg_r    <= x_neg;
              ovf_pend <= sgn_in && (bus.X == MinNeg) && (bus.Y == '1);
              busy_r   <= 1'b1;
              state    <= StRun;
            end else begin
              q_r      <= '1;
              r_r      <= bus.X;
              sign_r   <= 1'b1;
              zero_r   <= 1'b0;
              parity_r <= ^{WIDTH{1'b1}};
              ovf_r    <= 1'b0;
              dz_r     <= 1'b1;
              done_r   <= 1'b1;
              state    <= StDone;
            end
          end
        end
        StRun: begin
          dvd <= dvd << 1;
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            q_r      <= q_fin;
            r_r      <= r_fin;
            sign_r   <= q_fin[WIDTH-1];
            zero_r   <= (q_fin == '0);
            parity_r <= ^q_fin;
            ovf_r    <= ovf_pend;
            dz_r     <= 1'b0;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state    <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.Q        = q_r;
  assign bus.R        = r_r;
  assign bus.Sign     = sign_r;
  assign bus.Zero     = zero_r;
  assign bus.Parity   = parity_r;
  assign bus.Overflow = ovf_r;
  assign bus.DivZero  = dz_r;
endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16 against an arithmetic reference model.
module tb_seq_div16;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_div16_if #(.WIDTH(W)) bus ();
  seq_div16 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic logic [36:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic sg);
    logic [15:0] q, r;
    logic        ov, dz;
    int          sx, sy;
    dz = (y == 16'd0);
    ov = 1'b0;
    if (dz) begin
      q = 16'hFFFF;
      r = x;
    end else if (!sg) begin
      q = x / y;
      r = x % y;
    end else if (x == 16'h8000 && y == 16'hFFFF) begin
      q  = 16'h8000;
      r  = 16'h0000;
      ov = 1'b1;
    end else begin
      sx = int'($signed(x));
      sy = int'($signed(y));
      q  = 16'(sx / sy);
      r  = 16'(sx % sy);
    end
    return {q, r, q[15], (q == 16'd0), ^q, ov, dz};
  endfunction

  function automatic logic [36:0] result();
    return {bus.Q, bus.R, bus.Sign, bus.Zero, bus.Parity, bus.Overflow, bus.DivZero};
  endfunction

  function automatic logic [38:0] all_outs();
    return {bus.busy, bus.done, result()};
  endfunction

  // Issue one divide from a negedge; returns captured result, done latency and busy count.
  // interfere pulses start with other operands mid-run.
  task automatic do_div(input logic [15:0] x, input logic [15:0] y, input bit interfere,
                        output logic [36:0] res, output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.X     = x;
    bus.Y     = y;
    lat       = -1;
    bcnt      = 0;
    res       = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (interfere && i == 5) begin
        bus.start = 1'b1;
        bus.X     = ~x;
        bus.Y     = 16'd3;
      end
      if (interfere && i == 6) bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = i;
        res = result();
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.X     = 16'd9;
    bus.Y     = 16'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs() !== 39'd0) begin
      errors++;
      $display("FAIL reset_idle: got %h want 0", all_outs());
    end
  endtask

  task automatic test_directed();
    logic [15:0] xs [3] = '{16'd1000, 16'hFFFF, 16'd3};
    logic [15:0] ys [3] = '{16'd7, 16'd1, 16'd10};
    logic [15:0] qs [3] = '{16'd142, 16'hFFFF, 16'd0};
    logic [15:0] rs [3] = '{16'd6, 16'd0, 16'd3};
    logic [36:0] res, exp_res;
    int lat, bcnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      do_div(xs[k], ys[k], 1'b0, res, lat, bcnt);
      exp_res = {qs[k], rs[k], qs[k][15], (qs[k] == 16'd0), ^qs[k], 1'b0, 1'b0};
      checks++;
      if (res !== exp_res) begin
        errors++;
        $display("FAIL directed_%0d: got %h want %h", k, res, exp_res);
      end
      checks++;
      if (lat !== 17 || bcnt !== 16) begin
        errors++;
        $display("FAIL directed_timing_%0d: got lat=%0d busy=%0d want 17/16", k, lat, bcnt);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || result() !== exp_res) begin
        errors++;
        $display("FAIL directed_hold_%0d: got done=%b res=%h want 0/%h",
                 k, bus.done, result(), exp_res);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [36:0] res;
    int lat, bcnt;
    @(negedge clk);
    do_div(16'd5, 16'd0, 1'b0, res, lat, bcnt);
    checks++;
    if (res !== {16'hFFFF, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL div_zero: got %h want %h", res, {16'hFFFF, 16'd5, 5'b10001});
    end
    checks++;
    if (lat !== 1 || bcnt !== 0) begin
      errors++;
      $display("FAIL div_zero_timing: got lat=%0d busy=%0d want 1/0", lat, bcnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] res;
    int lat, bcnt;
    @(negedge clk);
    do_div(16'd1000, 16'd7, 1'b1, res, lat, bcnt);
    checks++;
    if (res !== model(16'd1000, 16'd7, 1'b0) || lat !== 17) begin
      errors++;
      $display("FAIL ignore_start: got %h lat=%0d want %h lat=17",
               res, lat, model(16'd1000, 16'd7, 1'b0));
    end
    // Still in the DONE cycle: the next start must be accepted immediately.
    do_div(16'd40000, 16'd123, 1'b0, res, lat, bcnt);
    checks++;
    if (res !== model(16'd40000, 16'd123, 1'b0) || lat !== 17 || bcnt !== 16) begin
      errors++;
      $display("FAIL back_to_back: got %h lat=%0d busy=%0d want %h lat=17 busy=16",
               res, lat, bcnt, model(16'd40000, 16'd123, 1'b0));
    end
  endtask

  task automatic test_reset_abort();
    logic [36:0] res;
    int lat, bcnt, bad;
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 16'd100;
    bus.Y     = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== 39'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %h want 0", all_outs());
    end
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", bad);
    end
    do_div(16'd100, 16'd3, 1'b0, res, lat, bcnt);
    checks++;
    if (res !== {16'd33, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0} || lat !== 17) begin
      errors++;
      $display("FAIL abort_fresh: got %h lat=%0d want q=33 r=1 lat=17", res, lat);
    end
  endtask

  task automatic test_random(input logic sg, input int n);
    logic [36:0] res;
    logic [15:0] x, y;
    int lat, bcnt;
    for (int k = 0; k < n; k++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       y = 16'd0;
        1, 2:    y = 16'($urandom_range(1, 15));
        3:       y = 16'hFFFF;
        default: y = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_div(x, y, 1'b0, res, lat, bcnt);
      checks++;
      if (res !== model(x, y, sg)) begin
        errors++;
        $display("FAIL random_%0d sg=%b x=%h y=%h: got %h want %h",
                 k, sg, x, y, res, model(x, y, sg));
      end
      checks++;
      if (lat !== ((y == 16'd0) ? 1 : 17)) begin
        errors++;
        $display("FAIL random_timing_%0d: got lat=%0d want %0d",
                 k, lat, (y == 16'd0) ? 1 : 17);
      end
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    logic [36:0] res;
    int lat, bcnt;
    bus.sgn = 1'b1;
    @(negedge clk);
    do_div(16'hFFF9, 16'd2, 1'b0, res, lat, bcnt);
    checks++;
    if (res[36:5] !== {16'hFFFD, 16'hFFFF} || lat !== 17) begin
      errors++;
      $display("FAIL signed_neg7_div2: got %h lat=%0d want q=fffd r=ffff", res, lat);
    end
    do_div(16'h8000, 16'hFFFF, 1'b0, res, lat, bcnt);
    checks++;
    if (res !== {16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL signed_overflow: got %h want q=8000 r=0 sign=1 ovf=1", res);
    end
    test_random(1'b1, 30);
    bus.sgn = 1'b0;
    test_random(1'b0, 10);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
`ifdef SIGNED_DIV_EN
    bus.sgn   = 1'b0;
`endif
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_random(1'b0, 40);
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_div16.md
Name: seq_div16

Overview:
- Iterative restoring divider: the inverse datapath to the team's 16-bit carry-lookahead adder/flag unit.
- Takes dividend X and divisor Y and produces quotient Q and remainder R, one quotient bit per clock.
- Reports the same status-flag set as the adder (Sign, Zero, Parity, Overflow) plus DivZero, so both blocks can sit behind a common ALU result/flag mux.
- Uses a start/busy/done handshake toward the ALU sequencer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when the block is ready.
- X  input  WIDTH  dividend; sampled on the accepted start edge.
- Y  input  WIDTH  divisor; sampled on the accepted start edge.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; Q, R and flags are valid from this cycle.
- Q  output  WIDTH  quotient (registered).
- R  output  WIDTH  remainder (registered).
- Sign  output  1  Q[WIDTH-1].
- Zero  output  1  high when Q == 0.
- Parity  output  1  XOR-reduction of Q.
- Overflow  output  1  signed overflow (see Optional Feature); 0 when the feature is compiled out.
- DivZero  output  1  high when the divisor was 0.
- sgn  input  1  signed-mode select; port exists only with SIGNED_DIV_EN.

Behaviour:
- Reset: state IDLE. busy, done, Q, R, Sign, Zero, Parity, Overflow and DivZero are all 0.
  - rst overrides everything, including start in the same cycle.
  - rst during RUN aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and Y != 0:
  - Latch X, Y and sgn.
  - Clear the partial remainder; load the iteration counter with WIDTH.
  - Go to RUN.
- IDLE/DONE with start=1 and Y == 0:
  - Go directly to DONE.
  - Q = all ones, R = X, DivZero = 1, Overflow = 0.
  - Flags are computed from that Q.
- RUN, each cycle:
  - Shift the next dividend bit (MSB first) into the partial remainder, one bit wider than WIDTH.
  - Trial-subtract the divisor. If there is no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. When it reaches 0, go to DONE.
  - busy = 1 throughout RUN.
- Entry to DONE: register Q, R and flags. done = 1 for exactly one cycle, then the state returns to IDLE unless a new start is accepted in that cycle.
- Latency:
  - Start accepted at edge k gives busy=1 in cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1.
  - Divide-by-zero gives done=1 in cycle k+1.
- start during RUN is ignored (not queued).
- Q, R and flags hold their values after done until the next completion or reset.
- Back-to-back operation: start asserted in the DONE cycle is accepted, so throughput is WIDTH+1 cycles per divide.
- DivZero and Overflow update only at completion.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- With the macro defined:
  - The sgn port exists.
  - When sgn=1, X and Y are two's complement. Magnitudes are divided.
  - Q is negated if the operand signs differ; R takes the sign of X (truncating division).
  - Sign correction is applied when the results are registered at DONE, so latency is unchanged.
  - X = most negative value and Y = -1: Q = most negative value, R = 0, Overflow = 1.
  - sgn=0 gives identical behaviour to the unsigned build.
- Without the macro: no sgn port, unsigned only, Overflow is tied to 0.

Test Plan:
- Reset then X=1000, Y=7, start one cycle -> busy for 16 cycles; done in cycle 17 after the start edge; Q=142 (0x008E), R=6; Sign=0, Zero=0, Parity=0, DivZero=0.
- X=0xFFFF, Y=1 -> Q=0xFFFF, R=0, Sign=1, Parity=0. X=3, Y=10 -> Q=0, R=3, Zero=1.
- X=5, Y=0 -> done one cycle after start; Q=0xFFFF, R=5, DivZero=1, busy never asserted.
- Assert start again during RUN with different operands -> ignored, original result delivered. Then assert start in the DONE cycle -> second result arrives 17 cycles later.
- Assert rst at iteration 8 of 100/3 -> next cycle all outputs 0, state IDLE, no done pulse. A fresh 100/3 afterwards -> Q=33, R=1.
- SIGNED_DIV_EN, sgn=1:
  - -7/2 -> Q=0xFFFD, R=0xFFFF.
  - 0x8000/0xFFFF -> Q=0x8000, R=0, Overflow=1, Sign=1.
